// File: rtl/mpu_pkg.sv
// Shared MPU definitions: matrix geometry, loader states and the packed element offset.
package mpu_pkg;

    localparam int MPU_N = 5;
    localparam int MPU_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // Bit offset of element (i,j) inside the packed N x N matrix word.
    function automatic int unsigned elem_offset(input int unsigned i, input int unsigned j);
        return MPU_W * (j + MPU_N * i);
    endfunction

endpackage

// File: rtl/mpu_matrix_loader_if.sv
// Element stream in, packed matrix out. Both channels transfer on a cycle where valid && ready;
// the producer holds data/valid stable until accepted, and ready never depends on a future valid.
interface mpu_matrix_loader_if;
    import mpu_pkg::*;

    logic signed [MPU_W-1:0]         in_data;
    logic                            in_valid;
    logic                            in_ready;
    logic [MPU_N*MPU_N*MPU_W-1:0]    matrix;
    logic [7:0]                      size;
    logic                            out_valid;
    logic                            out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, matrix, size, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, matrix, size, out_valid
    );

endinterface

// File: rtl/mpu_matrix_loader.sv
// Loads a size x size signed int8 matrix (row-major stream) into a packed 5x5 word for the MPU.
// Build option MPU_LOADER_IDENTITY_PAD_EN: unused diagonal positions are padded with 1 instead of 0.
module mpu_matrix_loader
    import mpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic signed [7:0]       i_cfg_size,
    mpu_matrix_loader_if.slave      bus,
    output logic                    o_busy,
    output logic                    o_err,
    output state_t                  o_state
);

    localparam int MW = MPU_N * MPU_N * MPU_W;
    localparam logic signed [7:0] N_S = 8'(MPU_N);

    state_t          r_state;
    state_t          w_next;
    logic [MW-1:0]   r_matrix;
    logic [MW-1:0]   w_pad;
    logic [7:0]      r_size;
    logic [2:0]      r_i;
    logic [2:0]      r_j;
    logic            r_err;
    logic            w_size_ok;
    logic            w_accept;
    logic            w_beat;
    logic            w_last_col;
    logic            w_last;
    logic [7:0]      w_off;
    logic            w_in_ready;
    logic            w_out_valid;

    assign w_size_ok  = (i_cfg_size > 8'sd0) && (i_cfg_size <= N_S);
    assign w_accept   = i_start && (r_state == IDLE) && w_size_ok;
    assign w_beat     = bus.in_valid && (r_state == LOAD);
    assign w_last_col = (r_j == r_size[2:0] - 3'd1);
    assign w_last     = w_last_col && (r_i == r_size[2:0] - 3'd1);
    assign w_off      = 8'(elem_offset(32'(r_i), 32'(r_j)));

    // Pad pattern loaded on an accepted start; only valid sizes 1..N reach the matrix.
    always_comb begin
        w_pad = '0;
`ifdef MPU_LOADER_IDENTITY_PAD_EN
        for (int k = 0; k < MPU_N; k++) begin
            if (k >= int'(i_cfg_size)) begin
                w_pad[8'(elem_offset(k, k)) +: MPU_W] = 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = LOAD;
            end
            LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_last) w_next = PRESENT;
            end
            PRESENT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_matrix <= '0;
            r_size   <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= i_start && (r_state == IDLE) && !w_size_ok;
            if (w_accept) begin
                r_size   <= i_cfg_size;
                r_matrix <= w_pad;
                r_i      <= '0;
                r_j      <= '0;
            end else if (w_beat) begin
                r_matrix[w_off +: MPU_W] <= bus.in_data;
                // Counters return to 0 after the final element so they never exceed N-1.
                if (w_last) begin
                    r_i <= '0;
                    r_j <= '0;
                end else if (w_last_col) begin
                    r_j <= '0;
                    r_i <= r_i + 3'd1;
                end else begin
                    r_j <= r_j + 3'd1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.matrix    = r_matrix;
    assign bus.size      = r_size;
    assign o_busy        = (r_state != IDLE);
    assign o_err         = r_err;
    assign o_state       = r_state;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed and randomized bench for mpu_matrix_loader; honours MPU_LOADER_IDENTITY_PAD_EN in its model.
module tb_mpu_matrix_loader;
    import mpu_pkg::*;

    localparam int MW = MPU_N * MPU_N * MPU_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic signed [7:0] cfg_size = '0;
    logic              busy;
    logic              err;
    state_t            state;

    int errors = 0;
    int checks = 0;
    logic [MPU_W-1:0] exp_q[$];

    mpu_matrix_loader_if bus();

    mpu_matrix_loader dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_cfg_size (cfg_size),
        .bus        (bus),
        .o_busy     (busy),
        .o_err      (err),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: stream position k lands at row k/n, column k%n of the 5x5 grid.
    function automatic logic [MW-1:0] model(input int n);
        logic [MW-1:0] m;
        logic [7:0]    off;
        m = '0;
`ifdef MPU_LOADER_IDENTITY_PAD_EN
        for (int k = n; k < MPU_N; k++) begin
            off = 8'((k * MPU_N + k) * MPU_W);
            m[off +: MPU_W] = 8'd1;
        end
`endif
        for (int k = 0; k < exp_q.size(); k++) begin
            off = 8'(((k / n) * MPU_N + (k % n)) * MPU_W);
            m[off +: MPU_W] = exp_q[k];
        end
        return m;
    endfunction

    task automatic fill_random(input int n);
        exp_q.delete();
        repeat (n * n) exp_q.push_back(8'($urandom_range(255, 0)));
    endtask

    task automatic load(input int n, input int smin, input int smax, input int ign_at);
        start = 1'b1;
        cfg_size = 8'(n);
        tick();
        start = 1'b0;
        check("busy_in_load", MW'(busy), MW'(1'b1));
        for (int k = 0; k < exp_q.size(); k++) begin
            repeat ($urandom_range(smax, smin)) begin
                bus.in_valid = 1'b0;
                tick();
            end
            if (k == exp_q.size() - 1) check("out_valid_before_last", MW'(bus.out_valid), '0);
            bus.in_valid = 1'b1;
            bus.in_data = exp_q[k];
            if (k == ign_at) begin
                start = 1'b1;
                cfg_size = 8'sd3;
            end
            tick();
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
        check("out_valid_after_last", MW'(bus.out_valid), MW'(1'b1));
        check("in_ready_present", MW'(bus.in_ready), '0);
        check("size", MW'(bus.size), MW'(8'(n)));
        check("matrix", bus.matrix, model(n));
    endtask

    task automatic present(input int hold, input int n);
        logic [MW-1:0] m;
        m = model(n);
        for (int c = 0; c < hold; c++) begin
            bus.out_ready = 1'b0;
            tick();
            check("hold_out_valid", MW'(bus.out_valid), MW'(1'b1));
            check("hold_matrix", bus.matrix, m);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_drop", MW'(bus.out_valid), '0);
        check("state_idle", MW'(state), MW'(IDLE));
        check("busy_idle", MW'(busy), '0);
        check("matrix_kept", bus.matrix, m);
    endtask

    initial begin
        int bad [3];
        int n;
        bad = '{0, 6, -3};
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;

        repeat (3) tick();
        check("rst_state", MW'(state), MW'(IDLE));
        check("rst_matrix", bus.matrix, '0);
        check("rst_size", MW'(bus.size), '0);
        check("rst_in_ready", MW'(bus.in_ready), '0);
        check("rst_out_valid", MW'(bus.out_valid), '0);
        check("rst_busy", MW'(busy), '0);
        check("rst_err", MW'(err), '0);
        rst = 1'b0;
        tick();

        // 2x2 load, no stalls
        exp_q.delete();
        for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
        load(2, 0, 0, -1);
        check("elem_1_0", MW'(bus.matrix[40 +: 8]), MW'(8'd3));
        present(0, 2);

        // Illegal sizes: 0, 6, -3
        for (int b = 0; b < 3; b++) begin
            start = 1'b1;
            cfg_size = 8'(bad[b]);
            tick();
            start = 1'b0;
            check("err_pulse", MW'(err), MW'(1'b1));
            check("err_busy", MW'(busy), '0);
            check("err_in_ready", MW'(bus.in_ready), '0);
            check("err_state", MW'(state), MW'(IDLE));
            tick();
            check("err_clear", MW'(err), '0);
        end
        check("err_size_kept", MW'(bus.size), MW'(8'd2));
        check("err_matrix_kept", bus.matrix, model(2));

        // 3x3 with in_valid low every other cycle, then 5 cycles of backpressure
        exp_q.delete();
        for (int k = 1; k <= 9; k++) exp_q.push_back(8'(k));
        load(3, 1, 1, -1);
        present(5, 3);

        // Reset after 7 of 16 beats
        fill_random(4);
        start = 1'b1;
        cfg_size = 8'sd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = exp_q[k];
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_state", MW'(state), MW'(IDLE));
        check("mid_rst_matrix", bus.matrix, '0);
        check("mid_rst_size", MW'(bus.size), '0);
        check("mid_rst_busy", MW'(busy), '0);
        check("mid_rst_in_ready", MW'(bus.in_ready), '0);
        check("mid_rst_out_valid", MW'(bus.out_valid), '0);
        tick();
        rst = 1'b0;
        tick();

        // 1x1 load of -5
        exp_q.delete();
        exp_q.push_back(8'hFB);
        load(1, 0, 0, -1);
        present(1, 1);

        // 5x5 identity with a start pulse of size 3 during the stream
        exp_q.delete();
        for (int k = 0; k < 25; k++) exp_q.push_back((k % 6 == 0) ? 8'd1 : 8'd0);
        load(5, 0, 0, 10);
        present(0, 5);

        // Randomized loads
        repeat (10) begin
            n = $urandom_range(5, 1);
            fill_random(n);
            load(n, 0, 2, -1);
            present($urandom_range(3, 0), n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
